reg_shadow_bank: RTL and testbench

Parametrised multi-channel double-buffered register bank for the DDS control path, such as frequency and phase tuning words per channel. The host loads staging registers one byte at a time. A masked commit then copies the staged words to the active outputs, either immediately or deferred to a sync strobe such as a phase-accumulator wrap. Each updated channel raises a one-cycle update pulse.

---
 rtl/reg_shadow_bank.sv | 169 ++++++++++++++++
 tb/tb_reg_shadow_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_shadow_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_shadow_bank
//  Purpose  : Multi-channel double-buffered register bank for the DDS control
//             path. The host fills per-channel staging words one byte at a
//             time. A masked commit copies staging to the active outputs,
//             either at once or deferred to a sync strobe. Every loaded
//             channel pulses its update flag for one cycle.
//  Ports    : clk, rst_n         - clock, asynchronous active-low reset
//             wr_i, ch_i,
//             byte_sel_i, byte_i - byte write into staging
//             commit_i,
//             commit_mask_i,
//             sync_mode_i        - commit request (immediate or deferred)
//             sync_i             - strobe that fires a deferred commit
//             dout_o             - active words, channel n at [n*DATA_W +: DATA_W]
//             upd_o              - one-cycle pulse per loaded channel
//             dirty_o            - staging written since last apply
//             pending_o          - deferred commit armed
//             err_o              - one-cycle pulse on an out-of-range write
//  Notes    : DATA_W must be a multiple of 8 (>= 8); NUM_CH >= 1.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_shadow_bank #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int BS_W   = ((DATA_W / 8) > 1) ? $clog2(DATA_W / 8) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic [BS_W-1:0]          byte_sel_i,
  input  logic [7:0]               byte_i,
  input  logic                     commit_i,
  input  logic [NUM_CH-1:0]        commit_mask_i,
  input  logic                     sync_mode_i,
  input  logic                     sync_i,
  output logic [NUM_CH*DATA_W-1:0] dout_o,
  output logic [NUM_CH-1:0]        upd_o,
  output logic [NUM_CH-1:0]        dirty_o,
  output logic                     pending_o,
  output logic                     err_o
);

  localparam int c_NUM_BYTES = DATA_W / 8;

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_ARMED = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nx;
  logic [NUM_CH-1:0] r_pend_mask;
  logic [NUM_CH-1:0] w_pend_nx;
  logic [NUM_CH-1:0] r_upd;
  logic [NUM_CH-1:0] r_dirty;
  logic              r_err;

  logic              w_ch_ok;
  logic              w_bs_ok;
  logic              w_wr_ok;
  logic [NUM_CH-1:0] w_wr_hit;
  logic [NUM_CH-1:0] w_apply;

  // Range checks only exist when the index field can encode values beyond
  // the populated range; a full power-of-two range is always valid.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_part
    localparam logic [CH_W-1:0] c_CH_LIM = CH_W'(NUM_CH);
    assign w_ch_ok = (ch_i < c_CH_LIM);
  end

  if (c_NUM_BYTES == (1 << BS_W)) begin : g_bs_full
    assign w_bs_ok = 1'b1;
  end else begin : g_bs_part
    localparam logic [BS_W-1:0] c_BS_LIM = BS_W'(c_NUM_BYTES);
    assign w_bs_ok = (byte_sel_i < c_BS_LIM);
  end

  assign w_wr_ok  = wr_i & w_ch_ok & w_bs_ok;
  assign w_wr_hit = w_wr_ok ? (NUM_CH'(1) << ch_i) : '0;

  // Commit control. IDLE handles immediate commits and arming; ARMED merges
  // further commits into the pending mask until sync fires. A sync in the
  // arming cycle is ignored because IDLE never looks at sync_i.
  always_comb begin
    w_apply    = '0;
    w_state_nx = r_state;
    w_pend_nx  = r_pend_mask;
    case (r_state)
      c_ST_IDLE: begin
        if (commit_i) begin
          if (!sync_mode_i) begin
            w_apply = commit_mask_i;
          end else if (|commit_mask_i) begin
            w_state_nx = c_ST_ARMED;
            w_pend_nx  = commit_mask_i;
          end
        end
      end
      c_ST_ARMED: begin
        if (sync_i) begin
          w_apply    = r_pend_mask | (commit_i ? commit_mask_i : '0);
          w_state_nx = c_ST_IDLE;
          w_pend_nx  = '0;
        end else if (commit_i) begin
          w_pend_nx = r_pend_mask | commit_mask_i;
        end
      end
      default: begin
        w_state_nx = c_ST_IDLE;
        w_pend_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_pend_mask <= '0;
      r_upd       <= '0;
      r_dirty     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pend_mask <= w_pend_nx;
      r_upd       <= w_apply;
      // A write in the apply cycle wins, so the channel stays dirty.
      r_dirty     <= (r_dirty & ~w_apply) | w_wr_hit;
      r_err       <= wr_i & ~w_wr_ok;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [DATA_W-1:0] r_stage;
    logic [DATA_W-1:0] r_active;

    // Both registers update at the same edge, so an apply always captures
    // the staging value from before a same-cycle byte write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stage  <= '0;
        r_active <= '0;
      end else begin
        if (w_apply[n]) begin
          r_active <= r_stage;
        end
        if (w_wr_hit[n]) begin
          for (int b = 0; b < c_NUM_BYTES; b++) begin
            if (byte_sel_i == BS_W'(b)) begin
              r_stage[b*8 +: 8] <= byte_i;
            end
          end
        end
      end
    end

    assign dout_o[n*DATA_W +: DATA_W] = r_active;
  end

  assign upd_o     = r_upd;
  assign dirty_o   = r_dirty;
  assign pending_o = (r_state == c_ST_ARMED);
  assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_shadow_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_shadow_bank
//  Purpose  : Self-checking bench for reg_shadow_bank. A 4x32 instance is
//             driven with directed scenarios and random traffic against a
//             behavioural model; a 1x8 instance covers out-of-range writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_shadow_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4 x 32 instance
  logic         wr, commit, smode, sync;
  logic [1:0]   ch, bs;
  logic [7:0]   bt;
  logic [3:0]   cmask;
  logic [127:0] dout;
  logic [3:0]   upd, dirty;
  logic         pend, err;

  // 1 x 8 instance
  logic         wr1, commit1, smode1, sync1;
  logic [0:0]   ch1, bs1, cmask1;
  logic [7:0]   bt1;
  logic [7:0]   dout1;
  logic [0:0]   upd1, dirty1;
  logic         pend1, err1;

  reg_shadow_bank #(.DATA_W(32), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_i(wr), .ch_i(ch), .byte_sel_i(bs),
    .byte_i(bt), .commit_i(commit), .commit_mask_i(cmask),
    .sync_mode_i(smode), .sync_i(sync), .dout_o(dout), .upd_o(upd),
    .dirty_o(dirty), .pending_o(pend), .err_o(err)
  );

  reg_shadow_bank #(.DATA_W(8), .NUM_CH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_i(wr1), .ch_i(ch1), .byte_sel_i(bs1),
    .byte_i(bt1), .commit_i(commit1), .commit_mask_i(cmask1),
    .sync_mode_i(smode1), .sync_i(sync1), .dout_o(dout1), .upd_o(upd1),
    .dirty_o(dirty1), .pending_o(pend1), .err_o(err1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model of the 4 x 32 bank
  logic [31:0] m_stage [4];
  logic [31:0] m_act   [4];
  logic [3:0]  m_dirty, m_pend, m_upd;
  logic        m_armed, m_err;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_stage[i] = '0;
      m_act[i]   = '0;
    end
    m_dirty = '0; m_pend = '0; m_upd = '0; m_armed = 1'b0; m_err = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [3:0] loaded;
    logic       ok;
    loaded = 4'b0;
    if (!m_armed && commit && !smode) loaded = cmask;
    if (m_armed && sync) loaded = m_pend | (commit ? cmask : 4'b0);
    for (int i = 0; i < 4; i++)
      if (loaded[i]) m_act[i] = m_stage[i];   // old staging, before the write
    m_upd = loaded;
    ok    = wr && (int'(ch) < 4) && (int'(bs) < 4);
    m_err = wr && !ok;
    if (ok) m_stage[ch][bs*8 +: 8] = bt;
    m_dirty = (m_dirty & ~loaded) | (ok ? (4'b0001 << ch) : 4'b0);
    if (!m_armed) begin
      if (commit && smode && (cmask != 4'b0)) begin
        m_armed = 1'b1;
        m_pend  = cmask;
      end
    end else if (sync) begin
      m_armed = 1'b0;
      m_pend  = 4'b0;
    end else if (commit) begin
      m_pend = m_pend | cmask;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_dout"},  dout,  {m_act[3], m_act[2], m_act[1], m_act[0]});
    check({tag, "_upd"},   upd,   m_upd);
    check({tag, "_dirty"}, dirty, m_dirty);
    check({tag, "_pend"},  pend,  m_armed);
    check({tag, "_err"},   err,   m_err);
  endtask

  task automatic set_in(input logic w, input logic [1:0] c, input logic [1:0] b,
                        input logic [7:0] d, input logic cm, input logic [3:0] mk,
                        input logic sm, input logic sy);
    wr = w; ch = c; bs = b; bt = d; commit = cm; cmask = mk; smode = sm; sync = sy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag);
    model_step();
    tick();
    compare_all(tag);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    wr1 = 0; ch1 = 0; bs1 = 0; bt1 = 0; commit1 = 0; cmask1 = 0; smode1 = 0; sync1 = 0;
    model_reset();
    #1;
    compare_all("reset");
    check("reset_dout1", dout1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: immediate commit of channel 1
    set_in(1, 1, 0, 8'h78, 0, 0, 0, 0); cyc("t1w0");
    set_in(1, 1, 1, 8'h56, 0, 0, 0, 0); cyc("t1w1");
    set_in(1, 1, 2, 8'h34, 0, 0, 0, 0); cyc("t1w2");
    set_in(1, 1, 3, 8'h12, 0, 0, 0, 0); cyc("t1w3");
    check("t1_dirty_pre", dirty, 4'b0010);
    set_in(0, 0, 0, 0, 1, 4'b0010, 0, 0); cyc("t1c");
    check("t1_ch1", dout[63:32], 32'h12345678);
    check("t1_upd", upd, 4'b0010);
    check("t1_dirty", dirty, 4'b0000);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("t1i");
    check("t1_upd_end", upd, 4'b0000);

    // 2: deferred commit of channels 0 and 2
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 2'(i), 8'hDD - 8'(i * 8'h11), 0, 0, 0, 0); cyc("t2w0");
      set_in(1, 2, 2'(i), 8'h04 - 8'(i), 0, 0, 0, 0);         cyc("t2w2");
    end
    set_in(0, 0, 0, 0, 1, 4'b0101, 1, 1); cyc("t2arm");  // same-cycle sync ignored
    check("t2_pend", pend, 1'b1);
    check("t2_ch0_hold", dout[31:0], 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("t2wait");
    set_in(0, 0, 0, 0, 0, 0, 0, 1); cyc("t2sync");
    check("t2_ch0", dout[31:0], 32'hAABBCCDD);
    check("t2_ch2", dout[95:64], 32'h01020304);
    check("t2_upd", upd, 4'b0101);
    check("t2_pend_clr", pend, 1'b0);

    // 3: merge while armed, staging write during ARMED
    set_in(0, 0, 0, 0, 1, 4'b0001, 1, 0); cyc("t3arm");
    set_in(1, 0, 0, 8'hEE, 0, 0, 0, 0);   cyc("t3w");
    set_in(0, 0, 0, 0, 1, 4'b1000, 0, 0); cyc("t3merge");
    check("t3_ch0_hold", dout[31:0], 32'hAABBCCDD);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);       cyc("t3sync");
    check("t3_ch0", dout[31:0], 32'hAABBCCEE);
    check("t3_upd", upd, 4'b1001);

    // 4: write and immediate commit in the same cycle
    set_in(1, 0, 2, 8'h99, 1, 4'b0001, 0, 0); cyc("t4a");
    check("t4_ch0_old", dout[31:0], 32'hAABBCCEE);
    check("t4_dirty0", dirty[0], 1'b1);
    set_in(0, 0, 0, 0, 1, 4'b0001, 0, 0); cyc("t4b");
    check("t4_ch0_new", dout[31:0], 32'hAA99CCEE);
    check("t4_dirty0_clr", dirty[0], 1'b0);

    // 6: reset while armed discards the pending commit
    set_in(0, 0, 0, 0, 1, 4'b0010, 1, 0); cyc("t6arm");
    check("t6_pend", pend, 1'b1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("t6rst");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1); cyc("t6sync");
    check("t6_upd", upd, 4'b0000);
    check("t6_dout", dout, 128'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 8'($urandom),
             ($urandom_range(0, 4) == 0), 4'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0));
      cyc("rnd");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // 5: out-of-range writes on the 1 x 8 instance
    wr1 = 1; ch1 = 0; bs1 = 0; bt1 = 8'h5A; tick();
    check("p1_dirty", dirty1, 1'b1);
    check("p1_err0", err1, 1'b0);
    wr1 = 0; commit1 = 1; cmask1 = 1; smode1 = 0; tick();
    check("p1_dout", dout1, 8'h5A);
    check("p1_upd", upd1, 1'b1);
    check("p1_dirty_clr", dirty1, 1'b0);
    commit1 = 0; wr1 = 1; ch1 = 1; bs1 = 0; bt1 = 8'h11; tick();
    check("p1_err_ch", err1, 1'b1);
    check("p1_dirty_ch", dirty1, 1'b0);
    ch1 = 0; bs1 = 1; bt1 = 8'h22; tick();
    check("p1_err_bs", err1, 1'b1);
    check("p1_dirty_bs", dirty1, 1'b0);
    wr1 = 0; commit1 = 1; cmask1 = 1; smode1 = 0; tick();
    check("p1_err_end", err1, 1'b0);
    check("p1_dout_keep", dout1, 8'h5A);
    check("p1_upd2", upd1, 1'b1);
    smode1 = 1; tick();
    check("p1_pend", pend1, 1'b1);
    check("p1_upd_arm", upd1, 1'b0);
    commit1 = 0; sync1 = 1; tick();
    check("p1_upd_sync", upd1, 1'b1);
    check("p1_pend_clr", pend1, 1'b0);
    sync1 = 0; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
